systolic_mem_responder: RTL and testbench
=========================================

// Module: systolic_mem_responder
// PURPOSE
//  Single-port scratchpad memory: the responder end of the systolic controller's memory bus
//  (mem_addr / mem_read_enable / mem_write_enable -> mem_read_data / mem_valid).
//  Serves matrix A/B loads and C stores for the accelerator.
//  Shares the array with a CPU side port, arbitrated with an anti-starvation counter.
// PARAMETERS
//  DEPTH        256  words implemented; addresses >= DEPTH are out of range
//  READ_LAT     2    accelerator read latency in cycles, legal 1..4
//  STARVE_LIMIT 8    consecutive CPU wait cycles before the CPU is promoted over accel reads
// PORTS
//  clk              in   1  clock, all logic on posedge
//  rst_n            in   1  asynchronous active-low reset
//  mem_addr         in   8  accelerator address
//  mem_read_enable  in   1  accelerator read request; may be held high while waiting
//  mem_write_enable in   1  accelerator write strobe, one word per cycle, no ack
//  mem_write_data   in   8  accelerator write data
//  mem_read_data    out  8  accelerator read data, valid only when mem_valid=1
//  mem_valid        out  1  one-cycle read-completion pulse
//  cpu_addr         in   8  CPU address
//  cpu_read_enable  in   1  CPU read request, held until cpu_ready
//  cpu_write_enable in   1  CPU write request, held until cpu_ready
//  cpu_write_data   in   8  CPU write data
//  cpu_read_data    out  8  CPU read data, valid when cpu_ready=1
//  cpu_ready        out  1  one-cycle CPU completion pulse
//  range_err        out  1  sticky flag: some access used an address >= DEPTH
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - All outputs go to 0.
//   - Any in-flight read and the starve counter are cleared.
//   - Array contents are not reset.
//   - A read cancelled by reset never produces mem_valid.
//  Accelerator writes
//   - Committed at the sampling edge, unconditionally.
//   - Always win over CPU access and over an accel read in the same cycle; that read is dropped.
//  Accelerator reads
//   - One read outstanding at most; busy = read in flight OR mem_valid high this cycle.
//   - Accepted when mem_read_enable=1, mem_write_enable=0, !busy, and CPU not promoted.
//   - Data is snapshot at the acceptance edge.
//   - mem_valid pulses exactly READ_LAT cycles after acceptance (READ_LAT=1 -> next cycle),
//     with the snapshot on mem_read_data.
//   - Requests seen while busy (including the mem_valid cycle) are ignored, not queued.
//     The requester re-asserts until valid, so repeated stale requests never cause a duplicate read.
//   - Writes landing during the flight window do not alter the returned data.
//  CPU port
//   - Granted in a cycle with no accel write and no accel read acceptance.
//   - Grant edge: write commits, or read samples the array.
//   - cpu_ready=1 the following cycle; cpu_read_data is held until the next CPU read completes.
//   - cpu_read_enable and cpu_write_enable both high: treated as a write.
//   - Next request may be granted in the cycle cpu_ready is high (back-to-back every 2 cycles).
//  Starvation
//   - Counter increments each cycle a CPU request waits; it clears on grant.
//   - At STARVE_LIMIT the CPU is promoted: it beats a pending accel read acceptance, never an accel write.
//   - The blocked accel read is simply not accepted and is retried by the requester.
//  Range
//   - addr >= DEPTH: reads return 0 with normal timing, writes are discarded, range_err sets.
//   - range_err clears only on reset.
//  FSM (read side)
//   - IDLE -> WAIT on acceptance.
//   - WAIT counts READ_LAT-1 cycles -> RESP.
//   - RESP (mem_valid=1) -> IDLE.
// TESTING
//  1 READ_LAT=2; preload [0x10]=0x5A; hold read @0x10 for 6 cycles
//    -> exactly one mem_valid, 2 cycles after first request, data 0x5A.
//  2 Requester pattern: valid cycle followed by new addr 0x11 ([0x11]=0x3C)
//    -> stale request in the valid cycle dropped; 0x3C returned 2 cycles later.
//  3 Accel write 0xA5 @0x20 same cycle as accel read @0x20
//    -> read dropped; a read next cycle returns 0xA5.
//  4 Accel read @0x30 ([0x30]=0x01); write 0xFF @0x30 during flight -> mem_valid data 0x01.
//  5 CPU read held while accel reads back-to-back
//    -> CPU granted no later than STARVE_LIMIT+1 cycles; cpu_ready pulses once with correct data.
//  6 DEPTH=128: write @0x90, then read @0x90 -> data 0, range_err=1.
//    Separately, assert rst_n=0 mid-flight -> no mem_valid, all outputs 0.

Source files
------------

// File: rtl/systolic_mem_responder.sv
// Scratchpad responder for the systolic controller's memory bus, shared with a CPU side port.
// Accelerator writes always win; CPU is promoted over accel reads after STARVE_LIMIT waits.
module systolic_mem_responder #(
   parameter int DEPTH        = 256,
   parameter int READ_LAT     = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] mem_addr,
   input  logic       mem_read_enable,
   input  logic       mem_write_enable,
   input  logic [7:0] mem_write_data,
   output logic [7:0] mem_read_data,
   output logic       mem_valid,
   input  logic [7:0] cpu_addr,
   input  logic       cpu_read_enable,
   input  logic       cpu_write_enable,
   input  logic [7:0] cpu_write_data,
   output logic [7:0] cpu_read_data,
   output logic       cpu_ready,
   output logic       range_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state_r, state_s;
   logic [1:0]    lat_cnt_r, lat_cnt_s;
   logic [SW-1:0] starve_r;
   logic [7:0]    mem_r [DEPTH];

   logic       accel_in_range_s, cpu_in_range_s;
   logic [7:0] accel_rdata_s, cpu_rdata_s;
   logic       busy_s, promote_s, cpu_req_s, accept_s, cpu_grant_s;

   // Address decode, arbitration and array read muxes
   always_comb begin
      accel_in_range_s = ({24'd0, mem_addr} < 32'(DEPTH));
      cpu_in_range_s   = ({24'd0, cpu_addr} < 32'(DEPTH));
      if (accel_in_range_s) begin
         accel_rdata_s = mem_r[mem_addr[AW-1:0]];
      end else begin
         accel_rdata_s = 8'h00;
      end
      if (cpu_in_range_s) begin
         cpu_rdata_s = mem_r[cpu_addr[AW-1:0]];
      end else begin
         cpu_rdata_s = 8'h00;
      end
      // busy covers the mem_valid cycle too, so a stale re-request there is ignored
      busy_s      = (state_r != IDLE);
      cpu_req_s   = cpu_read_enable | cpu_write_enable;
      promote_s   = cpu_req_s & (starve_r >= SW'(STARVE_LIMIT));
      accept_s    = mem_read_enable & ~mem_write_enable & ~busy_s & ~promote_s;
      cpu_grant_s = cpu_req_s & ~mem_write_enable & ~accept_s;
   end

   // Read-side FSM next state and latency countdown
   always_comb begin
      state_s   = state_r;
      lat_cnt_s = lat_cnt_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (READ_LAT <= 1) begin
                  state_s = RESP;
               end else begin
                  state_s   = WAIT;
                  lat_cnt_s = 2'(READ_LAT - 2);
               end
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            if (lat_cnt_r == 2'd0) begin
               state_s = RESP;
            end else begin
               lat_cnt_s = lat_cnt_r - 2'd1;
            end
         end
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Read FSM state, snapshot and accelerator outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         lat_cnt_r     <= 2'd0;
         mem_valid     <= 1'b0;
         mem_read_data <= 8'h00;
      end else begin
         state_r   <= state_s;
         lat_cnt_r <= lat_cnt_s;
         mem_valid <= (state_s == RESP);
         if (accept_s) begin
            mem_read_data <= accel_rdata_s;
         end
      end
   end

   // CPU completion, starvation counter and sticky range flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_r      <= '0;
         cpu_ready     <= 1'b0;
         cpu_read_data <= 8'h00;
         range_err     <= 1'b0;
      end else begin
         cpu_ready <= cpu_grant_s;
         if (cpu_grant_s && !cpu_write_enable) begin
            cpu_read_data <= cpu_rdata_s;
         end
         if (cpu_grant_s || !cpu_req_s) begin
            starve_r <= '0;
         end else if (starve_r < SW'(STARVE_LIMIT)) begin
            starve_r <= starve_r + SW'(1);
         end
         if ((mem_write_enable && !accel_in_range_s) ||
             (accept_s && !accel_in_range_s) ||
             (cpu_grant_s && !cpu_in_range_s)) begin
            range_err <= 1'b1;
         end
      end
   end

   // Array write port; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (mem_write_enable) begin
         if (accel_in_range_s) begin
            mem_r[mem_addr[AW-1:0]] <= mem_write_data;
         end
      end else if (cpu_grant_s && cpu_write_enable && cpu_in_range_s) begin
         mem_r[cpu_addr[AW-1:0]] <= cpu_write_data;
      end
   end

endmodule

// File: tb/tb_systolic_mem_responder.sv
// Directed and randomized bench for systolic_mem_responder (DEPTH=128 build).
module tb_systolic_mem_responder;

   localparam int DEPTH        = 128;
   localparam int READ_LAT     = 2;
   localparam int STARVE_LIMIT = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] mem_addr, mem_write_data, mem_read_data;
   logic       mem_read_enable, mem_write_enable, mem_valid;
   logic [7:0] cpu_addr, cpu_write_data, cpu_read_data;
   logic       cpu_read_enable, cpu_write_enable, cpu_ready, range_err;

   int         vectors    = 0;
   int         miscompares = 0;
   logic [7:0] ref_mem [256];

   systolic_mem_responder #(
      .DEPTH(DEPTH), .READ_LAT(READ_LAT), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_addr(mem_addr), .mem_read_enable(mem_read_enable),
      .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data), .mem_valid(mem_valid),
      .cpu_addr(cpu_addr), .cpu_read_enable(cpu_read_enable),
      .cpu_write_enable(cpu_write_enable), .cpu_write_data(cpu_write_data),
      .cpu_read_data(cpu_read_data), .cpu_ready(cpu_ready),
      .range_err(range_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic accel_write(input logic [7:0] a, input logic [7:0] d);
      mem_write_enable = 1'b1;
      mem_addr         = a;
      mem_write_data   = d;
      step();
      mem_write_enable = 1'b0;
      if (a < 8'(DEPTH)) ref_mem[a] = d;
   endtask

   // Holds a read until mem_valid; leaves the request asserted in the valid cycle
   task automatic accel_read(input logic [7:0] a, output logic [7:0] d, output int lat);
      mem_read_enable = 1'b1;
      mem_addr        = a;
      lat = 0;
      d   = 8'h00;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (mem_valid) begin
            lat = i;
            d   = mem_read_data;
            break;
         end
      end
   endtask

   initial begin
      logic [7:0] d, rdata;
      int         lat, cnt, idx, rc, rstep;
      bit         seen;
      int         pend;
      logic [7:0] pend_d, raddr, waddr, wdata;
      bit         holding, we_now, exp_range;

      rst_n = 1'b0;
      mem_addr = 8'h00; mem_read_enable = 1'b0; mem_write_enable = 1'b0; mem_write_data = 8'h00;
      cpu_addr = 8'h00; cpu_read_enable = 1'b0; cpu_write_enable = 1'b0; cpu_write_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check1("rst_mem_valid", mem_valid, 1'b0);
      check8("rst_mem_read_data", mem_read_data, 8'h00);
      check1("rst_cpu_ready", cpu_ready, 1'b0);
      check8("rst_cpu_read_data", cpu_read_data, 8'h00);
      check1("rst_range_err", range_err, 1'b0);
      rst_n = 1'b1;
      step();

      // 1: held read produces one pulse READ_LAT cycles later
      accel_write(8'h10, 8'h5A);
      accel_write(8'h11, 8'h3C);
      mem_read_enable = 1'b1;
      mem_addr = 8'h10;
      cnt = 0; idx = -1; seen = 1'b0; d = 8'h00;
      for (int i = 0; i < 6; i++) begin
         step();
         if (seen) mem_read_enable = 1'b0;
         if (mem_valid) begin
            cnt++; idx = i; d = mem_read_data; seen = 1'b1;
         end
      end
      check_int("t1_valid_count", cnt, 1);
      check_int("t1_valid_cycle", idx + 1, READ_LAT);
      check8("t1_data", d, 8'h5A);

      // 2: new address presented in the valid cycle is dropped, then served
      accel_read(8'h10, d, lat);
      check8("t2_first_data", d, 8'h5A);
      accel_read(8'h11, d, lat);
      check_int("t2_second_lat", lat, READ_LAT + 1);
      check8("t2_second_data", d, 8'h3C);
      mem_read_enable = 1'b0;
      step();
      check1("t2_no_dup_a", mem_valid, 1'b0);
      step();
      check1("t2_no_dup_b", mem_valid, 1'b0);

      // 3: write beats a same-cycle read; next-cycle read sees the new word
      mem_read_enable  = 1'b1;
      mem_write_enable = 1'b1;
      mem_addr         = 8'h20;
      mem_write_data   = 8'hA5;
      step();
      mem_write_enable = 1'b0;
      ref_mem[8'h20] = 8'hA5;
      accel_read(8'h20, d, lat);
      check_int("t3_lat", lat, READ_LAT);
      check8("t3_data", d, 8'hA5);
      mem_read_enable = 1'b0;
      step();

      // 4: write during the flight window does not affect returned data
      accel_write(8'h30, 8'h01);
      mem_read_enable = 1'b1;
      mem_addr = 8'h30;
      step();
      mem_read_enable = 1'b0;
      accel_write(8'h30, 8'hFF);
      check1("t4_valid", mem_valid, 1'b1);
      check8("t4_data", mem_read_data, 8'h01);
      step();
      accel_read(8'h30, d, lat);
      check8("t4_readback", d, 8'hFF);
      mem_read_enable = 1'b0;
      step();

      // 5a: CPU read against back-to-back accelerator reads
      accel_write(8'h40, 8'h77);
      cpu_read_enable = 1'b1;
      cpu_addr = 8'h40;
      mem_read_enable = 1'b1;
      mem_addr = 8'h10;
      rc = 0; rstep = 0; rdata = 8'h00;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (mem_valid) check8("t5_accel_data", mem_read_data, 8'h5A);
         if (cpu_ready) begin
            rc++;
            if (rc == 1) begin
               rstep = i; rdata = cpu_read_data;
            end
            cpu_read_enable = 1'b0;
         end
      end
      mem_read_enable = 1'b0;
      check_int("t5_ready_count", rc, 1);
      check8("t5_cpu_data", rdata, 8'h77);
      check1("t5_grant_bound", (rstep >= 1) && (rstep <= STARVE_LIMIT + 2), 1'b1);
      repeat (4) step();

      // 5b: after STARVE_LIMIT waits the CPU beats a pending accel read
      accel_write(8'h41, 8'h99);
      cpu_read_enable = 1'b1;
      cpu_addr = 8'h41;
      for (int i = 0; i < STARVE_LIMIT; i++) accel_write(8'h50, 8'(i));
      mem_read_enable = 1'b1;
      mem_addr = 8'h10;
      step();
      mem_read_enable = 1'b0;
      check1("t5b_cpu_ready", cpu_ready, 1'b1);
      check8("t5b_cpu_data", cpu_read_data, 8'h99);
      cpu_read_enable = 1'b0;
      step();
      check1("t5b_read_blocked_a", mem_valid, 1'b0);
      check1("t5b_no_dup_ready", cpu_ready, 1'b0);
      step();
      check1("t5b_read_blocked_b", mem_valid, 1'b0);

      // CPU write with both enables, then back-to-back CPU reads
      cpu_write_enable = 1'b1; cpu_read_enable = 1'b1;
      cpu_addr = 8'h60; cpu_write_data = 8'hC3;
      step();
      check1("cpu_wr_ready", cpu_ready, 1'b1);
      check8("cpu_wr_holds_rdata", cpu_read_data, 8'h99);
      cpu_write_enable = 1'b0; cpu_read_enable = 1'b0;
      ref_mem[8'h60] = 8'hC3;
      step();
      cpu_read_enable = 1'b1;
      step();
      check1("cpu_rd1_ready", cpu_ready, 1'b1);
      check8("cpu_rd1_data", cpu_read_data, 8'hC3);
      cpu_addr = 8'h41;
      step();
      check1("cpu_rd2_ready", cpu_ready, 1'b1);
      check8("cpu_rd2_data", cpu_read_data, 8'h99);
      cpu_read_enable = 1'b0;
      step();
      check1("cpu_rd2_done", cpu_ready, 1'b0);
      accel_read(8'h60, d, lat);
      check8("shared_array", d, 8'hC3);
      mem_read_enable = 1'b0;
      step();

      // 6: out-of-range access
      check1("t6_range_before", range_err, 1'b0);
      accel_write(8'h90, 8'h12);
      check1("t6_range_set", range_err, 1'b1);
      accel_read(8'h90, d, lat);
      check_int("t6_oob_lat", lat, READ_LAT);
      check8("t6_oob_data", d, 8'h00);
      accel_read(8'h10, d, lat);
      check8("t6_no_alias", d, 8'h5A);
      mem_read_enable = 1'b0;
      step();
      check1("t6_range_sticky", range_err, 1'b1);
      repeat (2) step();

      // Reset mid-flight cancels the read and clears outputs
      mem_read_enable = 1'b1;
      mem_addr = 8'h10;
      step();
      mem_read_enable = 1'b0;
      rst_n = 1'b0;
      #1;
      check1("rst2_mem_valid", mem_valid, 1'b0);
      check8("rst2_mem_read_data", mem_read_data, 8'h00);
      check1("rst2_cpu_ready", cpu_ready, 1'b0);
      check8("rst2_cpu_read_data", cpu_read_data, 8'h00);
      check1("rst2_range_err", range_err, 1'b0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check1("rst2_no_valid", mem_valid, 1'b0);
      end
      accel_read(8'h10, d, lat);
      check8("rst2_array_kept", d, 8'h5A);
      mem_read_enable = 1'b0;
      repeat (3) step();

      // Randomized accelerator traffic against a cycle-stamped reference
      for (int a = 0; a < DEPTH; a++) accel_write(8'(a), 8'($urandom));
      pend = -1; pend_d = 8'h00; raddr = 8'h00; holding = 1'b0; exp_range = 1'b0;
      for (int c = 0; c < 400; c++) begin
         we_now = ($urandom_range(0, 3) == 0);
         waddr  = 8'($urandom_range(0, 159));
         wdata  = 8'($urandom);
         if (!holding && ($urandom_range(0, 1) == 1)) begin
            holding = 1'b1;
            raddr   = 8'($urandom_range(0, 159));
         end
         mem_write_enable = we_now;
         mem_write_data   = wdata;
         mem_read_enable  = holding;
         mem_addr         = we_now ? waddr : raddr;
         if (we_now) begin
            if (waddr < 8'(DEPTH)) ref_mem[waddr] = wdata;
            else exp_range = 1'b1;
         end else if (holding && !(pend >= c)) begin
            pend = c + READ_LAT;
            if (raddr < 8'(DEPTH)) begin
               pend_d = ref_mem[raddr];
            end else begin
               pend_d = 8'h00;
               exp_range = 1'b1;
            end
         end
         step();
         check1("rnd_valid", mem_valid, pend == c + 1);
         if (pend == c + 1) begin
            check8("rnd_data", mem_read_data, pend_d);
            holding = 1'b0;
         end
         check1("rnd_range", range_err, exp_range);
      end
      mem_write_enable = 1'b0;
      mem_read_enable  = 1'b0;
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
